oka_seq_mul: RTL
================

OKA_SEQ_MUL -- requirements
Module: oka_seq_mul

Interface
- REQ-001: Parameter W, default 16; operand width in bits, even, legal range 8..64.
- REQ-002: Parameter OUT_REG, default 1; 1 = product held in an output register, 0 = product driven from the combine logic while in DONE.
- REQ-003: clk  input  1  single clock; all state updates on rising edge.
- REQ-004: rst  input  1  reset, synchronous, active-high.
- REQ-005: in_valid  input  1  operand pair presented.
- REQ-006: in_ready  output  1  block can accept an operand pair.
- REQ-007: a  input  W  operand A; GF(2) polynomial, bit i = coefficient of x^i.
- REQ-008: b  input  W  operand B; same encoding as a.
- REQ-009: out_valid  output  1  product available.
- REQ-010: out_ready  input  1  consumer accepts the product.
- REQ-011: y  output  2W-1  carry-less product a*b over GF(2)[x].
- REQ-012: busy  output  1  high in any state other than IDLE.

Function
- REQ-013: Arithmetic is carry-less throughout: all additions are XOR and there are no carries.
- REQ-014: One-level Karatsuba split, H=W/2: al=a[H-1:0], ah=a[W-1:H], bl=b[H-1:0], bh=b[W-1:H].
- REQ-015: Partial products (each 2H-1 bits): z0=al*bl, z2=ah*bh, z1=(al^ah)*(bl^bh).
- REQ-016: y = z0 ^ ((z0^z1^z2) << H) ^ (z2 << W), truncated to 2W-1 bits; the truncation loses no set bits.
- REQ-017: A single shared H-bit combinational carry-less multiplier computes the partial products, one per cycle.
- REQ-018: FSM states are IDLE, P0, P1, P2, DONE.
- REQ-019: IDLE: in_ready=1; on in_valid, latch a and b into operand registers, then go to P0.
- REQ-020: P0 computes z0 into a register, then goes to P1; P1 computes z2, then goes to P2; P2 computes z1, then goes to DONE.
- REQ-021: DONE: out_valid=1 and y holds the combined product.
- REQ-022: DONE with out_ready=1: the product is consumed and the FSM returns to IDLE on the next edge.
- REQ-023: DONE with out_ready=0: the FSM stays in DONE; y and out_valid stay stable until out_ready is seen.
- REQ-024: Latency: operands accepted at edge t -> out_valid=1 in the cycle following edge t+3, i.e. 4 cycles.
- REQ-025: Throughput: at most one product per 5 cycles with no backpressure.
- REQ-026: in_ready=0 in P0, P1, P2 and DONE.
- REQ-027: in_valid asserted while in_ready=0 is ignored; a and b may change freely outside the accept cycle without affecting the result.
- REQ-028: out_ready asserted outside DONE has no effect.
- REQ-029: OUT_REG=1: y is registered on entry to DONE and does not glitch while in DONE.
- REQ-030: OUT_REG=0: y is combinational from the z0/z1/z2 registers and is valid only while out_valid=1.
- REQ-031: y is don't-care while out_valid=0; the bench checks y only when out_valid=1.
- REQ-032: A handshake in DONE and an in_valid in the same cycle do not accept the new operands; they are accepted no earlier than the cycle after the return to IDLE.

Reset
- REQ-033: rst=1 at an edge forces state IDLE, in_ready=1, out_valid=0, busy=0, and clears the operand, z0, z1, z2 and y registers to 0.
- REQ-034: rst overrides all other inputs, including a handshake in the same cycle.
- REQ-035: rst asserted mid-operation (P0..DONE) abandons the operation; no out_valid for that operand pair ever appears.
- REQ-036: First accept is possible in the cycle after rst deasserts.

Verification
- REQ-037: W=16; a=0x0003, b=0x0003, out_ready=1 -> y=0x0000_0005 with out_valid exactly 4 cycles after accept.
- REQ-038: W=16; a=0x8000, b=0x8000 -> y=0x4000_0000 (x^30); a=0x0101, b=0x0101 -> y=0x0001_0001.
- REQ-039: W=16; a=0xFFFF, b=0x0001, out_ready held 0 for 10 cycles -> out_valid and y=0x0000_FFFF stable for all 10 cycles, in_ready=0 throughout, a single handshake on release.
- REQ-040: W=16; accept an operand pair, drive rst=1 in P1 -> next cycle in_ready=1, out_valid=0, busy=0; the abandoned result never appears.
- REQ-041: W=16 and W=64; back-to-back random stream with random out_ready, both OUT_REG values -> every y matches a bit-serial carry-less reference model, with products in order and no loss or duplication.
- REQ-042: in_valid held 1 with changing a and b during P0..DONE -> only the operands from the accept cycle affect the product.

Source files
------------

// File: rtl/oka_seq_mul.sv
// Sequential carry-less (GF(2)[x]) multiplier, one-level Karatsuba.
// One shared H-bit multiplier produces z0, z2, z1 on successive cycles.
module oka_seq_mul #(
   parameter int W       = 16,
   parameter int OUT_REG = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*W-2:0]   y,
   output logic             busy
);

   localparam int H  = W / 2;
   localparam int ZW = 2 * H - 1;
   localparam int YW = 2 * W - 1;

   typedef enum logic [2:0] {
      IDLE,
      P0,
      P1,
      P2,
      DONE
   } state_t;

   state_t          state;
   logic [W-1:0]    a_q;
   logic [W-1:0]    b_q;
   logic [ZW-1:0]   z0;
   logic [ZW-1:0]   z1;
   logic [ZW-1:0]   z2;
   logic [YW-1:0]   y_q;
   logic [YW-1:0]   y_comb;
   logic [H-1:0]    mx;
   logic [H-1:0]    my;
   logic [ZW-1:0]   prod;

   function automatic logic [ZW-1:0] clmul(
      input logic [H-1:0] p,
      input logic [H-1:0] q
   );
      logic [ZW-1:0] r;
      r = '0;
      for (int i = 0; i < H; i++) begin
         if (q[i]) r = r ^ (ZW'(p) << i);
      end
      return r;
   endfunction

   // Recombine: z0 + (z0+z1+z2)*x^H + z2*x^W, all XOR.
   function automatic logic [YW-1:0] combine(
      input logic [ZW-1:0] l,
      input logic [ZW-1:0] m,
      input logic [ZW-1:0] h
   );
      logic [ZW-1:0] mid;
      mid = l ^ m ^ h;
      return YW'(l) ^ (YW'(mid) << H) ^ (YW'(h) << W);
   endfunction

   // Operand select for the shared multiplier, one partial product per state.
   always_comb begin
      mx = '0;
      my = '0;
      unique case (state)
         P0: begin
            mx = a_q[H-1:0];
            my = b_q[H-1:0];
         end
         P1: begin
            mx = a_q[W-1:H];
            my = b_q[W-1:H];
         end
         P2: begin
            mx = a_q[H-1:0] ^ a_q[W-1:H];
            my = b_q[H-1:0] ^ b_q[W-1:H];
         end
         default: ;
      endcase
   end

   assign prod = clmul(mx, my);

   // Unregistered product path, valid only in DONE.
   always_comb begin
      y_comb = combine(z0, z1, z2);
   end

   assign y = (OUT_REG != 0) ? y_q : y_comb;

   // Control FSM with registered handshake/status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         z0        <= '0;
         z1        <= '0;
         z2        <= '0;
         y_q       <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q      <= a;
                  b_q      <= b;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= P0;
               end
            end
            P0: begin
               z0    <= prod;
               state <= P1;
            end
            P1: begin
               z2    <= prod;
               state <= P2;
            end
            P2: begin
               z1        <= prod;
               y_q       <= combine(z0, prod, z2);
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               busy      <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule
